// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_if -- bundle of the fetch-stage control, redirect, instruction-memory
// and decode-facing signals.
//
//   PC_Sel      [1:0]  next-PC select from control (2'b01 = ALU target)
//   Inst_Kill          squash the current fetch (jump / taken branch)
//   alu_target  [31:0] redirect target from the X-stage ALU
//   stall              downstream stall, freezes the fetch stage
//   icache_addr [31:0] instruction-memory read address (sync read)
//   icache_re          instruction-memory read enable
//   icache_dout [31:0] instruction-memory read data (one cycle after addr)
//   inst        [31:0] instruction presented to decode
//   pc_F        [31:0] address of the instruction on inst
//   inst_valid         inst is a real instruction, not a bubble
//
// master: the surrounding pipeline / memory side.  slave: fetch_stage.
// ---------------------------------------------------------------------------
interface fetch_if;
    logic [1:0]  PC_Sel;
    logic        Inst_Kill;
    logic [31:0] alu_target;
    logic        stall;
    logic [31:0] icache_addr;
    logic        icache_re;
    logic [31:0] icache_dout;
    logic [31:0] inst;
    logic [31:0] pc_F;
    logic        inst_valid;

    modport master (
        output PC_Sel, Inst_Kill, alu_target, stall, icache_dout,
        input  icache_addr, icache_re, inst, pc_F, inst_valid
    );

    modport slave (
        input  PC_Sel, Inst_Kill, alu_target, stall, icache_dout,
        output icache_addr, icache_re, inst, pc_F, inst_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage -- instruction fetch for a pipeline with a synchronous-read
// instruction memory.  pc_F names the address whose data is on icache_dout
// this cycle; icache_addr is the next PC, so a redirect reaches decode one
// cycle after the kill.  During a stall the first word seen is captured so
// decode keeps a stable instruction even if the memory output drifts, and a
// redirect that arrives while stalled is parked until the stall releases.
//
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous, active-high
//   bus    fetch_if.slave (control, redirect, icache and decode signals)
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic   clk,
    input  logic   reset,
    fetch_if.slave bus
);

    logic [31:0] pc_reg;
    logic        valid_f;
    logic [31:0] hold_inst;
    logic        held;
    logic [31:0] redir_pc;
    logic        redir_pend;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] next_pc;

    // Instructions are word aligned; the ALU may hand over a byte address.
    function automatic logic [31:0] align_target(input logic [31:0] t);
        return {t[31:2], 2'b00};
    endfunction

    // Next-PC selection; a fresh redirect beats a parked one.
    always_comb begin
        redirect = bus.Inst_Kill && (bus.PC_Sel == 2'b01);
        target   = align_target(bus.alu_target);
        if (!valid_f)
            next_pc = pc_reg;
        else if (redirect && !bus.stall)
            next_pc = target;
        else if (redir_pend && !bus.stall)
            next_pc = redir_pc;
        else if (bus.stall)
            next_pc = pc_reg;
        else
            next_pc = pc_reg + 32'd4;
    end

    // Decode-facing outputs.  A parked redirect means the word at pc_F is on
    // the wrong path, so it is bubbled just like a live kill.
    always_comb begin
        bus.icache_addr = next_pc;
        bus.icache_re   = !(bus.stall && valid_f);
        bus.pc_F        = pc_reg;
        if (!valid_f || bus.Inst_Kill || redir_pend) begin
            bus.inst       = NOP_INST;
            bus.inst_valid = 1'b0;
        end else begin
            bus.inst       = held ? hold_inst : bus.icache_dout;
            bus.inst_valid = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg     <= RESET_PC;
            valid_f    <= 1'b0;
            held       <= 1'b0;
            hold_inst  <= NOP_INST;
            redir_pend <= 1'b0;
            redir_pc   <= 32'h0;
        end else begin
            // The first edge after reset launches the read of RESET_PC.
            valid_f <= 1'b1;
            pc_reg  <= next_pc;

            if (bus.stall && !held) begin
                hold_inst <= bus.icache_dout;
                held      <= 1'b1;
            end else if (!bus.stall) begin
                held <= 1'b0;
            end

            if (bus.stall && redirect) begin
                redir_pc   <= target;
                redir_pend <= 1'b1;
            end else if (!bus.stall) begin
                redir_pend <= 1'b0;
            end
        end
    end

endmodule
